eu_pipe_reg: RTL and testbench

EU_PIPE_REG -- requirements
Module: eu_pipe_reg

---
 rtl/eu_pipe_reg.sv | 85 ++++++++
 tb/tb_eu_pipe_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/eu_pipe_reg.sv
// eu_pipe_reg: 2-entry skid buffer moving NUM_WAYS issue slots in lockstep with registered ready.
// Optional EU_PIPE_DEBUG_INST_EN carries per-way 32-bit instruction words alongside the payload.
module eu_pipe_reg #(
  parameter int DATA_W   = 255,
  parameter int NUM_WAYS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_WAYS-1:0]        way_en_i,
  input  logic [NUM_WAYS*DATA_W-1:0] data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_WAYS-1:0]        way_en_o,
  output logic [NUM_WAYS*DATA_W-1:0] data_o,
`ifdef EU_PIPE_DEBUG_INST_EN
  input  logic [NUM_WAYS*32-1:0]     inst_i,
  output logic [NUM_WAYS*32-1:0]     inst_o,
`endif
  output logic [1:0]                 count_o
);
  localparam int DW = NUM_WAYS * DATA_W;
`ifdef EU_PIPE_DEBUG_INST_EN
  localparam int PW = DW + NUM_WAYS + NUM_WAYS * 32;
`else
  localparam int PW = DW + NUM_WAYS;
`endif
  logic [PW-1:0] in_pl, main_q, main_d, skid_q, skid_d;
  logic          main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q;
  logic          in_fire, out_fire;
`ifdef EU_PIPE_DEBUG_INST_EN
  assign in_pl = {inst_i, way_en_i, data_i};
  assign {inst_o, way_en_o, data_o} = main_q;
`else
  assign in_pl = {way_en_i, data_i};
  assign {way_en_o, data_o} = main_q;
`endif
  assign in_fire     = in_valid_i & rdy_q;
  assign out_fire    = main_v_q & out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_v_q;
  assign count_o     = {1'b0, main_v_q} + {1'b0, skid_v_q};
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (!main_v_q || out_fire) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = in_fire;
        skid_d   = in_fire ? in_pl : skid_q;
      end else begin
        main_v_d = in_fire;
        main_d   = in_fire ? in_pl : main_q;
      end
    end else if (in_fire) begin
      skid_v_d = 1'b1;
      skid_d   = in_pl;
    end
    // flush only kills validity; any data written this cycle is meaningless
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= ~skid_v_d;
    end
  end
endmodule

// File: tb/tb_eu_pipe_reg.sv
// tb_eu_pipe_reg: vector table plus scoreboard checks of eu_pipe_reg at NUM_WAYS 2 (directed) and 1/4 (random).
module tb_eu_pipe_reg;
  localparam int DW = 255;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic           flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [1:0]     way_en_i = 0;
  logic [2*DW-1:0] data_i = '0;
  logic           in_ready_o, out_valid_o;
  logic [1:0]     way_en_o, count_o;
  logic [2*DW-1:0] data_o;
  eu_pipe_reg u_m (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .way_en_i(way_en_i), .data_i(data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .way_en_o(way_en_o), .data_o(data_o), .count_o(count_o));
  logic       iv1 = 0, or1 = 0, we1 = 0, ir1, ov1, wo1;
  logic [7:0] d1 = 0, do1;
  logic [1:0] c1;
  eu_pipe_reg #(.DATA_W(8), .NUM_WAYS(1)) u_1 (
    .clk(clk), .reset_n(reset_n), .flush_i(1'b0), .in_valid_i(iv1), .in_ready_o(ir1),
    .way_en_i(we1), .data_i(d1), .out_valid_o(ov1), .out_ready_i(or1),
    .way_en_o(wo1), .data_o(do1), .count_o(c1));
  logic        iv4 = 0, or4 = 0, ir4, ov4;
  logic [3:0]  we4 = 0, wo4;
  logic [31:0] d4 = 0, do4;
  logic [1:0]  c4;
  eu_pipe_reg #(.DATA_W(8), .NUM_WAYS(4)) u_4 (
    .clk(clk), .reset_n(reset_n), .flush_i(1'b0), .in_valid_i(iv4), .in_ready_o(ir4),
    .way_en_i(we4), .data_i(d4), .out_valid_o(ov4), .out_ready_i(or4),
    .way_en_o(wo4), .data_o(do4), .count_o(c4));
  int vecs = 0, errs = 0, npop = 0;
  bit low_seen = 0;
  logic [511:0] qm[$];
  logic [63:0]  q1[$], q4[$];
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic logic [2*DW-1:0] mk(input logic [7:0] d);
    logic [2*DW-1:0] r;
    r = '0;
    r[7:0] = d;
    r[DW+7 -: 8] = ~d;
    return r;
  endfunction
  task automatic step_m(input bit iv, input bit ordy, input logic [1:0] we, input logic [7:0] d);
    in_valid_i = iv; out_ready_i = ordy; way_en_i = we; data_i = mk(d);
    if (!in_ready_o) low_seen = 1;
    if (out_valid_o && ordy) begin
      if (qm.size() == 0) chk("spurious_out", {511'b0, out_valid_o}, 512'd0);
      else begin chk("order", {way_en_o, data_o}, qm.pop_front()); npop++; end
    end
    if (iv && in_ready_o) qm.push_back({we, mk(d)});
    @(posedge clk); #1;
  endtask
  typedef struct {
    bit iv, ordy, fl; logic [1:0] we; logic [7:0] d;
    bit eov; logic [1:0] ecnt; bit eir; logic [1:0] ewe; logic [7:0] ed;
  } vec_t;
  vec_t tbl[14];
  bit st1, st4;
  logic [63:0] pv1, pv4;
  initial begin
    tbl[0]  = '{1,1,0,2'b01,8'hA5, 1,2'd1,1,2'b01,8'hA5};
    tbl[1]  = '{1,1,0,2'b11,8'h01, 1,2'd1,1,2'b11,8'h01};
    tbl[2]  = '{1,0,0,2'b10,8'h02, 1,2'd2,0,2'b11,8'h01};
    tbl[3]  = '{1,0,0,2'b10,8'h03, 1,2'd2,0,2'b11,8'h01};
    tbl[4]  = '{1,1,0,2'b00,8'h03, 1,2'd1,1,2'b10,8'h02};
    tbl[5]  = '{1,1,0,2'b00,8'h03, 1,2'd1,1,2'b00,8'h03};
    tbl[6]  = '{0,1,0,2'b00,8'h00, 0,2'd0,1,2'b00,8'h00};
    tbl[7]  = '{1,0,0,2'b11,8'h10, 1,2'd1,1,2'b11,8'h10};
    tbl[8]  = '{1,0,0,2'b11,8'h11, 1,2'd2,0,2'b11,8'h10};
    tbl[9]  = '{1,1,1,2'b11,8'h12, 0,2'd0,1,2'b00,8'h00};
    tbl[10] = '{0,1,0,2'b00,8'h00, 0,2'd0,1,2'b00,8'h00};
    tbl[11] = '{1,1,0,2'b01,8'h20, 1,2'd1,1,2'b01,8'h20};
    tbl[12] = '{0,0,0,2'b00,8'h00, 1,2'd1,1,2'b01,8'h20};
    tbl[13] = '{0,1,0,2'b00,8'h00, 0,2'd0,1,2'b00,8'h00};
    #12;
    chk("rst_valid", {511'b0, out_valid_o}, 512'd0);
    chk("rst_count", {510'b0, count_o}, 512'd0);
    chk("rst_ready", {511'b0, in_ready_o}, 512'd1);
    chk("rst_data", {way_en_o, data_o}, 512'd0);
    @(posedge clk); #1; reset_n = 1;
    foreach (tbl[i]) begin
      in_valid_i = tbl[i].iv; out_ready_i = tbl[i].ordy; flush_i = tbl[i].fl;
      way_en_i = tbl[i].we; data_i = mk(tbl[i].d);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {511'b0, out_valid_o}, {511'b0, tbl[i].eov});
      chk($sformatf("v%0d_count", i), {510'b0, count_o}, {510'b0, tbl[i].ecnt});
      chk($sformatf("v%0d_ready", i), {511'b0, in_ready_o}, {511'b0, tbl[i].eir});
      if (tbl[i].eov) chk($sformatf("v%0d_data", i), {way_en_o, data_o}, {tbl[i].ewe, mk(tbl[i].ed)});
    end
    flush_i = 0;
    for (int k = 1; k <= 8; k++) step_m(1, 1, 2'(k), 8'(k));
    step_m(0, 1, 0, 0);
    step_m(0, 1, 0, 0);
    chk("stream_count", npop, 8);
    chk("stream_ready_low", {511'b0, low_seen}, 512'd0);
    npop = 0;
    step_m(1, 0, 2'b01, 8'h31);
    step_m(1, 0, 2'b10, 8'h32);
    step_m(1, 0, 2'b11, 8'h33);
    chk("bp_count", {510'b0, count_o}, 512'd2);
    chk("bp_ready", {511'b0, in_ready_o}, 512'd0);
    chk("bp_qsize", qm.size(), 2);
    step_m(1, 1, 2'b11, 8'h33);
    step_m(1, 1, 2'b11, 8'h33);
    step_m(0, 1, 0, 0);
    step_m(0, 1, 0, 0);
    chk("bp_popped", npop, 3);
    step_m(1, 0, 2'b01, 8'h40);
    step_m(1, 0, 2'b01, 8'h41);
    chk("pre_rst_count", {510'b0, count_o}, 512'd2);
    #2 reset_n = 0; #1;
    qm.delete();
    chk("arst_valid", {511'b0, out_valid_o}, 512'd0);
    chk("arst_count", {510'b0, count_o}, 512'd0);
    chk("arst_ready", {511'b0, in_ready_o}, 512'd1);
    chk("arst_data", {way_en_o, data_o}, 512'd0);
    @(posedge clk); #1; reset_n = 1;
    in_valid_i = 1; out_ready_i = 1; way_en_i = 2'b10; data_i = mk(8'h50);
    @(posedge clk); #1;
    chk("post_rst_valid", {511'b0, out_valid_o}, 512'd1);
    chk("post_rst_data", {way_en_o, data_o}, {2'b10, mk(8'h50)});
    in_valid_i = 0;
    @(posedge clk); #1;
    st1 = 0; st4 = 0;
    for (int n = 0; n < 10010; n++) begin
      bit drain;
      drain = n >= 10000;
      if (st1) chk("stall1", {55'b0, wo1, do1}, pv1);
      if (st4) chk("stall4", {28'b0, wo4, do4}, pv4);
      iv1 = drain ? 1'b0 : 1'($urandom_range(0, 1));
      or1 = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      we1 = 1'($urandom); d1 = 8'($urandom);
      iv4 = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
      or4 = drain ? 1'b1 : 1'($urandom_range(0, 1));
      we4 = 4'($urandom); d4 = $urandom;
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("spurious1", {511'b0, ov1}, 512'd0);
        else chk("sb1", {55'b0, wo1, do1}, q1.pop_front());
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("spurious4", {511'b0, ov4}, 512'd0);
        else chk("sb4", {28'b0, wo4, do4}, q4.pop_front());
      end
      if (iv1 && ir1) q1.push_back({55'b0, we1, d1});
      if (iv4 && ir4) q4.push_back({28'b0, we4, d4});
      st1 = ov1 & ~or1; pv1 = {55'b0, wo1, do1};
      st4 = ov4 & ~or4; pv4 = {28'b0, wo4, do4};
      @(posedge clk); #1;
    end
    chk("drain1", q1.size(), 0);
    chk("drain4", q4.size(), 0);
    chk("drain1_valid", {511'b0, ov1}, 512'd0);
    chk("drain4_valid", {511'b0, ov4}, 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
